// File: rtl/smpl_queue_seq.sv
// Sample history queue for the FIR core: keeps the last DEPTH samples and, on each
// window write, streams them oldest-first with `sequencing` high, followed by TAIL zero cycles.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_FILL | queue filling after reset; the DEPTH-th write starts a window
// S_IDLE | queue full; every write replaces the oldest sample and starts a window
// S_SEQ  | window read-out plus tail; incoming writes are dropped and flag ovr
module smpl_queue_seq #(
    parameter int DEPTH = 1021,
    parameter int AW    = 10,
    parameter int TAIL  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wrt_smpl,
    input  logic signed [15:0] smpl_in,
    output logic               sequencing,
    output logic signed [15:0] smpl_out,
    output logic               full,
    output logic               ovr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(DEPTH + TAIL + 2);

    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(DEPTH + TAIL + 1);
    localparam logic [TW-1:0] TMR_TAIL = TW'(TAIL);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_IDLE = 2'd1,
        S_SEQ  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [AW-1:0]      new_ptr;
    logic [AW-1:0]      old_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      cnt;
    logic [TW-1:0]      tmr;
    logic signed [15:0] mem [DEPTH];
    logic signed [15:0] rd_data;

    logic accept;
    logic window_wr;
    logic tmr_done;
    logic seq_nx;
    logic tail_nx;

    function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    assign accept    = wrt_smpl && (state != S_SEQ);
    assign window_wr = accept && ((state == S_IDLE) || (cnt == CNT_LAST));
    assign tmr_done  = (tmr == '0);
    assign full      = (cnt == CNT_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FILL:  if (window_wr) state_nx = S_SEQ;
            S_IDLE:  if (window_wr) state_nx = S_SEQ;
            S_SEQ:   if (tmr_done)  state_nx = S_IDLE;
            default: state_nx = S_FILL;
        endcase
    end

    // The first SEQ cycle only issues the first read, so sequencing starts one timer step later.
    always_comb begin
        seq_nx  = 1'b0;
        tail_nx = 1'b0;
        if ((state == S_SEQ) && !tmr_done && (tmr != TMR_LOAD)) begin
            seq_nx = 1'b1;
        end
        if (tmr <= TMR_TAIL) begin
            tail_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            new_ptr    <= '0;
            old_ptr    <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            tmr        <= '0;
            sequencing <= 1'b0;
            smpl_out   <= '0;
            ovr        <= 1'b0;
        end else begin
            if (accept) begin
                new_ptr <= inc_ptr(new_ptr);
                if (state == S_IDLE) begin
                    old_ptr <= inc_ptr(old_ptr);
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            // When full, the slot just overwritten was the oldest, so the window starts one past it.
            if (window_wr) begin
                tmr    <= TMR_LOAD;
                rd_ptr <= (state == S_IDLE) ? inc_ptr(old_ptr) : old_ptr;
            end else if (state == S_SEQ) begin
                if (!tmr_done) begin
                    tmr <= tmr - TW'(1);
                end
                rd_ptr <= inc_ptr(rd_ptr);
            end

            if (wrt_smpl && (state == S_SEQ)) begin
                ovr <= 1'b1;
            end

            sequencing <= seq_nx;
            if (seq_nx) begin
                smpl_out <= tail_nx ? '0 : rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem[new_ptr] <= smpl_in;
        end
        rd_data <= mem[rd_ptr];
    end

endmodule
